// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory responder.
//   SZ_*    : request size encodings (2'b11 is handled like a word)
//   state_t : responder FSM states
//   CNT_W   : width of the latency down-counter (latency 0..15)
package mem_resp_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } state_t;

endpackage

// File: rtl/mem_resp_lane_unit.sv
// Byte-lane steering for the memory responder (purely combinational).
// Ports:
//   size     : access size (SZ_BYTE / SZ_HALF / SZ_WORD, 2'b11 = word)
//   addr_lo  : byte offset within the word
//   wdata    : right-justified store data
//   raw      : word currently held in storage
//   be       : byte enables for the write
//   wdata_sh : store data replicated onto every lane it could occupy
//   rdata    : selected lanes, right-justified and zero-extended
// Half and word accesses ignore the low offset bits they do not use, which
// gives natural-alignment masking for free.
module mem_resp_lane_unit
   import mem_resp_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] raw,
   output logic [3:0]  be,
   output logic [31:0] wdata_sh,
   output logic [31:0] rdata
);

   always_comb begin
      be       = 4'b1111;
      wdata_sh = wdata;
      rdata    = raw;
      case (size)
         SZ_BYTE: begin
            be       = 4'b0001 << addr_lo;
            wdata_sh = {4{wdata[7:0]}};
            rdata    = {24'b0, 8'(raw >> {addr_lo, 3'b000})};
         end
         SZ_HALF: begin
            be       = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_sh = {2{wdata[15:0]}};
            rdata    = {16'b0, 16'(raw >> {addr_lo[1], 4'b0000})};
         end
         SZ_WORD, 2'b11: begin
            be       = 4'b1111;
            wdata_sh = wdata;
            rdata    = raw;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the unified instruction/data bus.
// Accepts one request over valid/ready, waits LATENCY cycles, performs the
// access, then pulses resp_valid for one cycle with the read data.
// Ports:
//   clk, rst            : clock (rising edge), async active-low reset
//   req_valid/req_ready : request handshake
//   req_we, req_size    : write enable, size (byte/half/word)
//   req_addr, req_wdata : byte address, right-justified store data
//   resp_valid          : one-cycle response pulse
//   resp_rdata          : right-justified read data (0 for writes)
//   resp_err            : misaligned access flag
// Build option: MEM_RESP_MISALIGN_ERR_EN makes misaligned half/word accesses
// skip the write and respond with resp_err=1, resp_rdata=0. Without it the
// low address bits are masked and resp_err stays 0.
//
// state | meaning
// IDLE  | ready for a request; accept captures the request
// WAIT  | counting down latency; access happens when count hits 1
// RESP  | resp_valid high for this one cycle
module mem_responder
   import mem_resp_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2,
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;

   logic               cap_we;
   logic [1:0]         cap_size;
   logic [IDX_W+1:0]   cap_addr;
   logic [31:0]        cap_wdata;

   logic               acc_we;
   logic [1:0]         acc_size;
   logic [IDX_W+1:0]   acc_addr;
   logic [31:0]        acc_wdata;

   logic               accept, do_access, err_hit, wr_en;
   logic [3:0]         be;
   logic [31:0]        wdata_sh, rdata_al, raw_word, wr_word;
   logic [31:0]        mem [DEPTH_WORDS];

   // upper address bits only select aliases of the same word
   logic               addr_unused;
   assign addr_unused = ^req_addr[ADDR_W-1:IDX_W+2];

   assign accept = (state == IDLE) && req_valid;

   // With zero latency the access happens on the accept edge itself, so it
   // must use the live request rather than the capture registers.
   generate
      if (LATENCY == 0) begin : g_lat0
         assign acc_we    = req_we;
         assign acc_size  = req_size;
         assign acc_addr  = req_addr[IDX_W+1:0];
         assign acc_wdata = req_wdata;
         assign do_access = accept && rst;
      end else begin : g_latn
         assign acc_we    = cap_we;
         assign acc_size  = cap_size;
         assign acc_addr  = cap_addr;
         assign acc_wdata = cap_wdata;
         assign do_access = (state == WAIT) && (cnt == CNT_W'(1));
      end
   endgenerate

`ifdef MEM_RESP_MISALIGN_ERR_EN
   always_comb begin
      err_hit = 1'b0;
      case (acc_size)
         SZ_BYTE: err_hit = 1'b0;
         SZ_HALF: err_hit = acc_addr[0];
         default: err_hit = (acc_addr[1:0] != 2'b00);
      endcase
   end
`else
   assign err_hit = 1'b0;
`endif

   assign raw_word = mem[acc_addr[IDX_W+1:2]];
   assign wr_en    = do_access && acc_we && !err_hit;
   assign wr_word  = {be[3] ? wdata_sh[31:24] : raw_word[31:24],
                      be[2] ? wdata_sh[23:16] : raw_word[23:16],
                      be[1] ? wdata_sh[15:8]  : raw_word[15:8],
                      be[0] ? wdata_sh[7:0]   : raw_word[7:0]};

   mem_resp_lane_unit u_lane (
      .size     (acc_size),
      .addr_lo  (acc_addr[1:0]),
      .wdata    (acc_wdata),
      .raw      (raw_word),
      .be       (be),
      .wdata_sh (wdata_sh),
      .rdata    (rdata_al)
   );

   always_ff @(posedge clk) begin
      if (wr_en) mem[acc_addr[IDX_W+1:2]] <= wr_word;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = (LATENCY == 0) ? RESP : WAIT;
         end
         WAIT: begin
            if (cnt == CNT_W'(1)) state_nxt = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                cnt <= '0;
      else if (accept)                         cnt <= CNT_W'(LATENCY);
      else if ((state == WAIT) && (cnt != '0)) cnt <= cnt - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap_we    <= 1'b0;
         cap_size  <= SZ_BYTE;
         cap_addr  <= '0;
         cap_wdata <= '0;
      end else if (accept) begin
         cap_we    <= req_we;
         cap_size  <= req_size;
         cap_addr  <= req_addr[IDX_W+1:0];
         cap_wdata <= req_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else if (do_access) begin
         resp_rdata <= (acc_we || err_hit) ? '0 : rdata_al;
         resp_err   <= err_hit;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
   import mem_resp_pkg::*;

   localparam int LAT = 2;

   logic        clk, rst;
   logic        req_valid, req_valid0;
   logic        req_we;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        req_ready, resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        req_ready0, resp_valid0, resp_err0;
   logic [31:0] resp_rdata0;

   int n_checks = 0;
   int n_fail   = 0;
   bit held_prev = 0;

   // byte-addressed reference storage, one per DUT (index 1 = zero latency)
   logic [7:0] mb [2][4096];

   mem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_size(req_size), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err));

   mem_responder #(.DEPTH_WORDS(1024), .LATENCY(0), .ADDR_W(32)) dut0 (
      .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
      .req_we(req_we), .req_size(req_size), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid0), .resp_rdata(resp_rdata0),
      .resp_err(resp_err0));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit rdy(input bit d0);
      return d0 ? req_ready0 : req_ready;
   endfunction

   function automatic bit rsp(input bit d0);
      return d0 ? resp_valid0 : resp_valid;
   endfunction

   // Reference behaviour: sizes of 1/2/4 bytes, natural alignment by masking,
   // optional error on misalignment, addresses alias modulo 4096 bytes.
   function automatic void model(input int d, input bit we, input logic [1:0] sz,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 output logic [31:0] rd, output logic er);
      int nb, off, base;
      nb   = (sz == SZ_BYTE) ? 1 : (sz == SZ_HALF) ? 2 : 4;
      off  = int'(a % 4096);
      base = off - (off % nb);
      rd   = '0;
      er   = 1'b0;
`ifdef MEM_RESP_MISALIGN_ERR_EN
      if (off % nb != 0) er = 1'b1;
`endif
      if (er) return;
      for (int k = 0; k < nb; k++) begin
         if (we) mb[d][base + k] = wd[8*k +: 8];
         else    rd = rd | (32'(mb[d][base + k]) << (8*k));
      end
   endfunction

   // Called at a negedge. Returns wait before accept, cycles from accept to
   // response, and whether ready stayed low through WAIT/RESP.
   task automatic txn(input bit d0, input bit we, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] wd, input bit hold,
                      output logic [31:0] rd, output logic er,
                      output int wait_n, output int lat, output bit rdy_ok);
      req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
      if (d0) req_valid0 = 1'b1; else req_valid = 1'b1;
      wait_n = 0;
      while (!rdy(d0) && wait_n < 50) begin
         @(negedge clk);
         wait_n++;
      end
      @(negedge clk);
      if (!hold) begin
         req_valid = 1'b0; req_valid0 = 1'b0;
         req_we    = 1'($urandom);
         req_size  = 2'($urandom);
         req_addr  = $urandom;
         req_wdata = $urandom;
      end
      lat = 1; rdy_ok = 1'b1;
      while (!rsp(d0) && lat < 40) begin
         if (rdy(d0)) rdy_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (rdy(d0)) rdy_ok = 1'b0;
      rd = d0 ? resp_rdata0 : resp_rdata;
      er = d0 ? resp_err0 : resp_err;
   endtask

   task automatic do_txn(input string tag, input bit d0, input bit we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd, input bit hold,
                         output logic [31:0] rd);
      logic [31:0] exp_rd;
      logic        exp_er, er;
      int          wn, lat;
      bit          rok;
      model(d0 ? 1 : 0, we, sz, a, wd, exp_rd, exp_er);
      txn(d0, we, sz, a, wd, hold, rd, er, wn, lat, rok);
      check({tag, ".accept_wait"}, 32'(wn), held_prev ? 32'd1 : 32'd0);
      check({tag, ".latency"}, 32'(lat), d0 ? 32'd1 : 32'(LAT + 1));
      check({tag, ".ready_low"}, 32'(rok), 32'd1);
      check({tag, ".rdata"}, rd, exp_rd);
      check({tag, ".err"}, 32'(er), 32'(exp_er));
      if (!hold) begin
         @(negedge clk);
         check({tag, ".pulse_end"}, 32'(rsp(d0)), 32'd0);
         check({tag, ".idle_ready"}, 32'(rdy(d0)), 32'd1);
      end
      held_prev = hold;
   endtask

   initial begin
      logic [31:0] rd, a;
      logic [1:0]  sz;

      rst = 1'b0; req_valid = 1'b0; req_valid0 = 1'b0;
      req_we = 1'b0; req_size = SZ_BYTE; req_addr = '0; req_wdata = '0;
      repeat (2) @(negedge clk);
      check("reset.ready",  32'(req_ready), 32'd1);
      check("reset.valid",  32'(resp_valid), 32'd0);
      check("reset.rdata",  resp_rdata, 32'd0);
      check("reset.err",    32'(resp_err), 32'd0);
      check("reset.ready0", 32'(req_ready0), 32'd1);
      rst = 1'b1;
      @(negedge clk);

      // word round trip
      do_txn("rt.wr", 0, 1, SZ_WORD, 32'h40, 32'h1234_5678, 0, rd);
      do_txn("rt.rd", 0, 0, SZ_WORD, 32'h40, 32'h0, 0, rd);
      check("rt.value", rd, 32'h1234_5678);

      // reset during WAIT drops the pending write
      do_txn("rst.prep", 0, 1, SZ_WORD, 32'h10, 32'h1111_1111, 0, rd);
      do_txn("rst.prep_rd", 0, 0, SZ_WORD, 32'h10, 32'h0, 0, rd);
      req_we = 1'b1; req_size = SZ_WORD; req_addr = 32'h10; req_wdata = 32'hDEAD_BEEF;
      req_valid = 1'b1;
      check("rst.pre_accept_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      check("rst.in_wait_ready", 32'(req_ready), 32'd0);
      rst = 1'b0;
      #1;
      check("rst.async_ready", 32'(req_ready), 32'd1);
      check("rst.async_valid", 32'(resp_valid), 32'd0);
      check("rst.async_rdata", resp_rdata, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      do_txn("rst.readback", 0, 0, SZ_WORD, 32'h10, 32'h0, 0, rd);
      check("rst.readback_value", rd, 32'h1111_1111);

      // byte and half lanes
      do_txn("ln.w0", 0, 1, SZ_WORD, 32'h80, 32'h0, 0, rd);
      do_txn("ln.b",  0, 1, SZ_BYTE, 32'h82, 32'hAB, 0, rd);
      do_txn("ln.h",  0, 1, SZ_HALF, 32'h80, 32'hBEEF, 0, rd);
      do_txn("ln.rw", 0, 0, SZ_WORD, 32'h80, 32'h0, 0, rd);
      check("ln.word_value", rd, 32'h00AB_BEEF);
      do_txn("ln.rb", 0, 0, SZ_BYTE, 32'h82, 32'h0, 0, rd);
      check("ln.byte_value", rd, 32'h0000_00AB);

      // wrap, with a second request held through WAIT/RESP
      do_txn("wr.wr",    0, 1, SZ_WORD, 32'h1000, 32'hCAFE_F00D, 0, rd);
      do_txn("wr.rd",    0, 0, SZ_WORD, 32'h0000, 32'h0, 1, rd);
      check("wr.value", rd, 32'hCAFE_F00D);
      do_txn("wr.held",  0, 0, SZ_WORD, 32'h0000, 32'h0, 0, rd);
      check("wr.held_value", rd, 32'hCAFE_F00D);

      // misaligned word write onto 0x40 (holds 0x12345678)
      do_txn("ma.wr", 0, 1, SZ_WORD, 32'h42, 32'h55AA_1234, 0, rd);
      do_txn("ma.rd", 0, 0, SZ_WORD, 32'h40, 32'h0, 0, rd);
`ifdef MEM_RESP_MISALIGN_ERR_EN
      check("ma.value", rd, 32'h1234_5678);
`else
      check("ma.value", rd, 32'h55AA_1234);
`endif

      // zero latency: fill, then back-to-back reads with valid held
      for (int i = 0; i < 4; i++)
         do_txn("l0.wr", 1, 1, SZ_WORD, 32'h200 + 32'(4*i), $urandom, 0, rd);
      for (int i = 0; i < 4; i++)
         do_txn("l0.rd", 1, 0, SZ_WORD, 32'h200 + 32'(4*i), 32'h0, (i < 3), rd);

      // random traffic on both responders against the reference
      for (int i = 0; i < 16; i++) begin
         do_txn("rnd.init", 0, 1, SZ_WORD, 32'h100 + 32'(4*i), $urandom, 0, rd);
         do_txn("rnd.init0", 1, 1, SZ_WORD, 32'h300 + 32'(4*i), $urandom, 0, rd);
      end
      for (int i = 0; i < 80; i++) begin
         bit d0;
         d0 = (i % 3 == 2);
         a  = (d0 ? 32'h300 : 32'h100) + 32'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 1) a = a + 32'h1000 * 32'($urandom_range(1, 7));
         sz = 2'($urandom_range(0, 3));
         do_txn("rnd", d0, 1'($urandom), sz, a, $urandom, 0, rd);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
